decoder_pipe: RTL and testbench
===============================

Name: decoder_pipe

Overview:
- Registered, flow-controlled instruction decode stage: splits a MIPS-style instruction into op/rs/rt/rd/sham/funct/imm16/imm26 and produces an extended immediate of configurable width.
- Sits between fetch and register-read.
- Valid/ready handshake on both sides, with a 2-entry (output + skid) buffer so full throughput is kept while out_ready is registered downstream.
- Supports synchronous flush for branch/jump redirect.

Parameters:
- DATA_WIDTH, 32, instruction and imm_ext width; must be >= 32. Fields are always taken from instruction[31:0]; bits above 31 are ignored.
- PC_WIDTH, 32, width of the pc sideband carried alongside each instruction.

Ports:
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  synchronous active-high reset
- flush  input  1  discard all buffered entries and the current input
- in_valid  input  1  instruction/pc/ext_sign valid
- in_ready  output  1  stage can accept an entry this cycle
- instruction  input  DATA_WIDTH  raw instruction word
- pc  input  PC_WIDTH  address of instruction
- ext_sign  input  1  1 = sign-extend imm16, 0 = zero-extend
- out_valid  output  1  decoded entry valid
- out_ready  input  1  consumer accepts entry
- op  output  6  instruction[31:26]
- rs  output  5  instruction[25:21]
- rt  output  5  instruction[20:16]
- rd  output  5  instruction[15:11]
- sham  output  5  instruction[10:6]
- funct  output  6  instruction[5:0]
- imm16  output  16  instruction[15:0]
- imm26  output  26  instruction[25:0]
- imm_ext  output  DATA_WIDTH  imm16 extended per ext_sign latched with the entry
- pc_out  output  PC_WIDTH  pc of the presented entry

Behaviour:
- Storage: output register (OUT) and skid register (SKID); each holds {instruction, pc, ext_sign}. Decode is applied combinationally from OUT, or registered from the decoded values; either way outputs are a pure function of OUT contents.
- States: EMPTY (neither valid), ONE (OUT valid), FULL (OUT and SKID valid).
- in_ready = ~SKID valid. This is a registered state bit, with no combinational path from out_ready.
- Accept = in_valid & in_ready & ~flush. Consume = out_valid & out_ready.
- EMPTY:
  - accept -> ONE; entry loaded into OUT.
- ONE:
  - accept & consume -> ONE; OUT replaced by the new entry.
  - accept & ~consume -> FULL; new entry goes to SKID.
  - consume & ~accept -> EMPTY.
- FULL:
  - in_ready=0, so no accept.
  - consume -> ONE; SKID moves to OUT the same edge.
- Latency: an accepted entry is visible on out_valid/fields the next cycle when the stage was EMPTY or being drained.
- Ordering: entries leave strictly in acceptance order.
- Output stability: while out_valid=1 and out_ready=0, every output is held stable.
- Extension:
  - imm_ext = {{(DATA_WIDTH-16){imm16[15]}}, imm16} when ext_sign=1.
  - imm_ext = {{(DATA_WIDTH-16){1'b0}}, imm16} when ext_sign=0.
- flush:
  - Next state is EMPTY and the concurrent input is dropped.
  - Flush has priority over accept and consume.
  - in_ready and out_valid are asserted normally during the flush cycle, but a consume in that cycle still counts as a completed transfer.
- rst:
  - Overrides flush; next state is EMPTY.
  - out_valid=0; all field outputs, imm_ext and pc_out are 0; in_ready=1 after the reset edge.
  - Inputs are ignored while rst=1.
  - Mid-operation reset discards both entries.
- Data registers are not required to clear when invalid outside reset, but outputs must be 0 after reset until the first load.

Optional Feature:
- Macro: DECODER_PIPE_COUNT_EN.
- When defined:
  - Adds output decode_count [31:0], which increments by 1 on every consume and wraps 0xFFFFFFFF -> 0.
  - Cleared by rst; not cleared by flush.
  - A consume in a flush cycle is counted.
- When undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset, then in_valid=1, instruction=0x012A4020, pc=0x00400000, out_ready=1 -> next cycle out_valid=1, op=0x00, rs=9, rt=10, rd=8, sham=0, funct=0x20, pc_out=0x00400000.
- instruction=0x2128FFFF with ext_sign=1 -> op=0x08, rs=9, rt=8, imm16=0xFFFF, imm_ext=0xFFFFFFFF. Same word with ext_sign=0 -> imm_ext=0x0000FFFF. Jump 0x08000010 -> op=0x02, imm26=0x0000010.
- Back-pressure:
  - Stream A, B, C with out_ready=0.
  - Expect A presented; B accepted into SKID; in_ready=0 from the cycle after B is accepted; C held off; outputs stay at A.
  - Raise out_ready: A, B, C delivered in order with no loss or duplication.
- Full throughput: 8 back-to-back instructions with out_ready=1 always -> 8 consecutive out_valid cycles, 1-cycle latency, in_ready never drops.
- Flush in FULL state with in_valid=1 -> next cycle out_valid=0, in_ready=1, the input word is never emitted, and the subsequent stream resumes correctly.
- rst asserted in FULL state mid-stream -> all outputs 0, out_valid=0 next cycle; with DECODER_PIPE_COUNT_EN, decode_count=0, and after 3 consumes decode_count=3.

Source files
------------

// File: rtl/decoder_pipe.sv
// decoder_pipe: registered MIPS-style instruction decode stage with a
// valid/ready handshake and a 2-entry (output + skid) buffer.
// Optional macro DECODER_PIPE_COUNT_EN adds a 32-bit consume counter port.
module decoder_pipe #(
  parameter int DATA_WIDTH = 32,
  parameter int PC_WIDTH   = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] instruction,
  input  logic [PC_WIDTH-1:0]   pc,
  input  logic                  ext_sign,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [5:0]            op,
  output logic [4:0]            rs,
  output logic [4:0]            rt,
  output logic [4:0]            rd,
  output logic [4:0]            sham,
  output logic [5:0]            funct,
  output logic [15:0]           imm16,
  output logic [25:0]           imm26,
  output logic [DATA_WIDTH-1:0] imm_ext,
  output logic [PC_WIDTH-1:0]   pc_out
`ifdef DECODER_PIPE_COUNT_EN
  ,
  output logic [31:0]           decode_count
`endif
);

  typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

  state_t state, state_next;

  // Only the low 32 instruction bits carry fields, so only those are stored.
  logic [31:0]         out_instr, skid_instr;
  logic [PC_WIDTH-1:0] out_pc, skid_pc;
  logic                out_sign, skid_sign;

  logic accept, consume;
  logic load_out_in, load_out_skid, load_skid;

  // in_ready depends only on registered state, never on out_ready.
  assign in_ready  = (state != FULL);
  assign out_valid = (state != EMPTY);
  assign accept    = in_valid & in_ready & ~flush;
  assign consume   = out_valid & out_ready;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= EMPTY;
    else     state <= state_next;
  end

  // Next-state and buffer load selects; flush overrides accept and consume.
  always_comb begin
    state_next    = state;
    load_out_in   = 1'b0;
    load_out_skid = 1'b0;
    load_skid     = 1'b0;
    if (flush) begin
      state_next = EMPTY;
    end else begin
      case (state)
        EMPTY: begin
          if (accept) begin
            state_next  = ONE;
            load_out_in = 1'b1;
          end
        end
        ONE: begin
          if (accept && consume) begin
            load_out_in = 1'b1;
          end else if (accept) begin
            state_next = FULL;
            load_skid  = 1'b1;
          end else if (consume) begin
            state_next = EMPTY;
          end
        end
        FULL: begin
          if (consume) begin
            state_next    = ONE;
            load_out_skid = 1'b1;
          end
        end
        default: state_next = EMPTY;
      endcase
    end
  end

  // Entry storage; cleared on reset so outputs read 0 until the first load.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_instr  <= '0;
      out_pc     <= '0;
      out_sign   <= 1'b0;
      skid_instr <= '0;
      skid_pc    <= '0;
      skid_sign  <= 1'b0;
    end else begin
      if (load_out_in) begin
        out_instr <= instruction[31:0];
        out_pc    <= pc;
        out_sign  <= ext_sign;
      end else if (load_out_skid) begin
        out_instr <= skid_instr;
        out_pc    <= skid_pc;
        out_sign  <= skid_sign;
      end
      if (load_skid) begin
        skid_instr <= instruction[31:0];
        skid_pc    <= pc;
        skid_sign  <= ext_sign;
      end
    end
  end

  // Field decode is a pure function of the output register.
  assign op      = out_instr[31:26];
  assign rs      = out_instr[25:21];
  assign rt      = out_instr[20:16];
  assign rd      = out_instr[15:11];
  assign sham    = out_instr[10:6];
  assign funct   = out_instr[5:0];
  assign imm16   = out_instr[15:0];
  assign imm26   = out_instr[25:0];
  assign imm_ext = {{(DATA_WIDTH-16){out_sign & out_instr[15]}}, out_instr[15:0]};
  assign pc_out  = out_pc;

`ifdef DECODER_PIPE_COUNT_EN
  // Counts every completed transfer, including one made during a flush cycle.
  always_ff @(posedge clk) begin
    if (rst)          decode_count <= '0;
    else if (consume) decode_count <= decode_count + 32'd1;
  end
`endif

endmodule

// File: tb/tb_decoder_pipe.sv
// tb_decoder_pipe: directed, table-driven bench for decoder_pipe.
// Define DECODER_PIPE_COUNT_EN to also exercise the decode_count port.
module tb_decoder_pipe;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, in_ready, ext_sign, out_valid, out_ready;
  logic [31:0] instruction, pc, imm_ext, pc_out;
  logic [5:0]  op, funct;
  logic [4:0]  rs, rt, rd, sham;
  logic [15:0] imm16;
  logic [25:0] imm26;
`ifdef DECODER_PIPE_COUNT_EN
  logic [31:0] decode_count;
`endif

  int checks   = 0;
  int failures = 0;

  decoder_pipe #(.DATA_WIDTH(32), .PC_WIDTH(32)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .instruction(instruction), .pc(pc), .ext_sign(ext_sign),
    .out_valid(out_valid), .out_ready(out_ready),
    .op(op), .rs(rs), .rt(rt), .rd(rd), .sham(sham), .funct(funct),
    .imm16(imm16), .imm26(imm26), .imm_ext(imm_ext), .pc_out(pc_out)
`ifdef DECODER_PIPE_COUNT_EN
    , .decode_count(decode_count)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic        sign;
    logic [5:0]  op;
    logic [4:0]  rs, rt, rd, sham;
    logic [5:0]  funct;
    logic [15:0] imm16;
    logic [25:0] imm26;
    logic [31:0] imm_ext;
  } vec_t;

  vec_t vecs[6];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic send(input logic [31:0] i, input logic [31:0] p, input logic s);
    in_valid    = 1'b1;
    instruction = i;
    pc          = p;
    ext_sign    = s;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    //            instr         pc            s     op     rs     rt     rd     sham   funct  imm16     imm26         imm_ext
    vecs[0] = '{32'h012A4020, 32'h00400000, 1'b0, 6'h00, 5'd9,  5'd10, 5'd8,  5'd0,  6'h20, 16'h4020, 26'h12A4020, 32'h00004020};
    vecs[1] = '{32'h2128FFFF, 32'h00400004, 1'b1, 6'h08, 5'd9,  5'd8,  5'd31, 5'd31, 6'h3F, 16'hFFFF, 26'h128FFFF, 32'hFFFFFFFF};
    vecs[2] = '{32'h2128FFFF, 32'h00400008, 1'b0, 6'h08, 5'd9,  5'd8,  5'd31, 5'd31, 6'h3F, 16'hFFFF, 26'h128FFFF, 32'h0000FFFF};
    vecs[3] = '{32'h08000010, 32'h0040000C, 1'b1, 6'h02, 5'd0,  5'd0,  5'd0,  5'd0,  6'h10, 16'h0010, 26'h0000010, 32'h00000010};
    vecs[4] = '{32'h8C857FFC, 32'h00400010, 1'b1, 6'h23, 5'd4,  5'd5,  5'd15, 5'd31, 6'h3C, 16'h7FFC, 26'h0857FFC, 32'h00007FFC};
    vecs[5] = '{32'h00000000, 32'h00000000, 1'b1, 6'h00, 5'd0,  5'd0,  5'd0,  5'd0,  6'h00, 16'h0000, 26'h0000000, 32'h00000000};

    // Reset with live-looking inputs that must be ignored.
    rst = 1'b1; flush = 1'b0; out_ready = 1'b0;
    send(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1);
    step(); step();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready",  in_ready,  1);
    chk("rst_op",        op,        0);
    chk("rst_rs",        rs,        0);
    chk("rst_funct",     funct,     0);
    chk("rst_imm26",     imm26,     0);
    chk("rst_imm_ext",   imm_ext,   0);
    chk("rst_pc_out",    pc_out,    0);
    rst = 1'b0; in_valid = 1'b0;
    step();
    chk("idle_after_rst", out_valid, 0);

    // Table-driven single-entry decode, one-cycle latency.
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      send(vecs[i].instr, vecs[i].pc, vecs[i].sign);
      step();
      in_valid = 1'b0;
      chk($sformatf("v%0d_valid", i),   out_valid, 1);
      chk($sformatf("v%0d_op", i),      op,        vecs[i].op);
      chk($sformatf("v%0d_rs", i),      rs,        vecs[i].rs);
      chk($sformatf("v%0d_rt", i),      rt,        vecs[i].rt);
      chk($sformatf("v%0d_rd", i),      rd,        vecs[i].rd);
      chk($sformatf("v%0d_sham", i),    sham,      vecs[i].sham);
      chk($sformatf("v%0d_funct", i),   funct,     vecs[i].funct);
      chk($sformatf("v%0d_imm16", i),   imm16,     vecs[i].imm16);
      chk($sformatf("v%0d_imm26", i),   imm26,     vecs[i].imm26);
      chk($sformatf("v%0d_imm_ext", i), imm_ext,   vecs[i].imm_ext);
      chk($sformatf("v%0d_pc_out", i),  pc_out,    vecs[i].pc);
      step();
      chk($sformatf("v%0d_drained", i), out_valid, 0);
    end

    // Back-pressure: A presented, B into skid, C held off.
    out_ready = 1'b0;
    send(32'h00221820, 32'h100, 1'b0);
    step();
    chk("bp_a_valid", out_valid, 1);
    chk("bp_a_pc",    pc_out,    32'h100);
    chk("bp_a_ready", in_ready,  1);
    send(32'h00221822, 32'h104, 1'b0);
    step();
    chk("bp_b_pc",    pc_out,    32'h100);
    chk("bp_b_ready", in_ready,  0);
    send(32'h00221824, 32'h108, 1'b0);
    step();
    chk("bp_c_hold_pc",    pc_out,   32'h100);
    chk("bp_c_hold_ready", in_ready, 0);
    step();
    chk("bp_stable_pc",    pc_out, 32'h100);
    chk("bp_stable_funct", funct,  6'h20);
    out_ready = 1'b1;
    step();
    chk("bp_deliver_b_pc",    pc_out,   32'h104);
    chk("bp_deliver_b_funct", funct,    6'h22);
    chk("bp_deliver_b_ready", in_ready, 1);
    step();
    in_valid = 1'b0;
    chk("bp_deliver_c_pc",    pc_out, 32'h108);
    chk("bp_deliver_c_funct", funct,  6'h24);
    step();
    chk("bp_empty", out_valid, 0);

    // Full throughput: 8 back-to-back entries.
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      send(32'h20000000 | i, 32'h400 + 4 * i, 1'b0);
      step();
      chk($sformatf("tp%0d_valid", i), out_valid, 1);
      chk($sformatf("tp%0d_pc", i),    pc_out,    32'h400 + 4 * i);
      chk($sformatf("tp%0d_imm16", i), imm16,     i);
      chk($sformatf("tp%0d_ready", i), in_ready,  1);
    end
    in_valid = 1'b0;
    step();
    chk("tp_drained", out_valid, 0);

    // Flush while FULL with an input offered.
    out_ready = 1'b0;
    send(32'h00000001, 32'h200, 1'b0);
    step();
    send(32'h00000002, 32'h204, 1'b0);
    step();
    chk("fl_full_ready", in_ready, 0);
    flush = 1'b1;
    send(32'h00000003, 32'h208, 1'b0);
    step();
    flush = 1'b0; in_valid = 1'b0;
    chk("fl_full_valid", out_valid, 0);
    chk("fl_full_ready_after", in_ready, 1);
    step();
    chk("fl_full_stays_empty", out_valid, 0);

    // Flush while ONE with an input that would otherwise be accepted.
    send(32'h00000004, 32'h210, 1'b0);
    step();
    flush = 1'b1;
    send(32'h00000005, 32'h214, 1'b0);
    step();
    flush = 1'b0; in_valid = 1'b0;
    chk("fl_one_valid", out_valid, 0);
    step();
    chk("fl_one_dropped", out_valid, 0);

    // Stream resumes after flush.
    out_ready = 1'b1;
    send(32'h3C01ABCD, 32'h220, 1'b1);
    step();
    in_valid = 1'b0;
    chk("resume_pc",      pc_out,  32'h220);
    chk("resume_op",      op,      6'h0F);
    chk("resume_rt",      rt,      5'd1);
    chk("resume_imm_ext", imm_ext, 32'hFFFFABCD);
    step();
    chk("resume_drained", out_valid, 0);

    // Reset while FULL.
    out_ready = 1'b0;
    send(32'h012A4020, 32'h300, 1'b1);
    step();
    send(32'h2128FFFF, 32'h304, 1'b1);
    step();
    chk("rf_full_ready", in_ready, 0);
    rst = 1'b1; in_valid = 1'b0;
    step();
    rst = 1'b0;
    chk("rf_valid",   out_valid, 0);
    chk("rf_ready",   in_ready,  1);
    chk("rf_pc",      pc_out,    0);
    chk("rf_rs",      rs,        0);
    chk("rf_funct",   funct,     0);
    chk("rf_imm_ext", imm_ext,   0);
`ifdef DECODER_PIPE_COUNT_EN
    chk("rf_count", decode_count, 0);
`endif

    // Three consumes after reset.
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      send(32'h00000020 + i, 32'h500 + 4 * i, 1'b0);
      step();
      chk($sformatf("post_rst%0d_pc", i), pc_out, 32'h500 + 4 * i);
    end
    in_valid = 1'b0;
    step();
    chk("post_rst_drained", out_valid, 0);
`ifdef DECODER_PIPE_COUNT_EN
    chk("post_rst_count", decode_count, 3);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
